// File: rtl/aes_round_iter_core.sv
// -----------------------------------------------------------------------------
// aes_round_iter_core
//   Iterative AES-128/192/256 cipher core. One shared round datapath executes
//   one round per clock, with encrypt/decrypt chosen per request. The key
//   schedule is expanded combinationally from the registered key and indexed
//   by the round counter.
//
//   Ports
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     in_valid   request present on in_mode/in_key/in_data
//     in_ready   core can accept a request this cycle
//     in_mode    0 = encrypt, 1 = decrypt
//     in_key     cipher key (KEY_LEN bits)
//     in_data    plaintext (enc) or ciphertext (dec), 128 bits
//     out_valid  out_data holds a result
//     out_ready  consumer takes out_data this cycle
//     out_data   result block
//     out_mode   in_mode of the request that produced out_data
//     busy       high while a block is in flight or waiting to be taken
//
//   Bit ordering on in_key/in_data/out_data: vector bit 0 is the MSB of byte 0
//   (the FIPS-197 bit sequence laid out from index 0 upward). Internally the
//   blocks are bit-reversed so byte 0 sits in the top byte, which keeps the
//   byte/column arithmetic in the conventional orientation.
// -----------------------------------------------------------------------------
module aes_round_iter_core #(
  parameter int KEY_LEN = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [KEY_LEN-1:0] in_key,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               out_mode,
  output logic               busy
);

  localparam int         NK   = KEY_LEN / 32;
  localparam int         NR   = NK + 6;
  localparam int         NW   = 4 * (NR + 1);
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_round_iter_core: KEY_LEN must be 128, 192 or 256, got %0d", KEY_LEN);
  end

  // ---------------------------------------------------------------------------
  // GF(2^8) and S-box helpers. The S-box is built from the field inverse and
  // the affine map instead of a lookup table.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // ---------------------------------------------------------------------------
  // Round transformations on a block with byte n at bits [127-8n -: 8];
  // byte n is row n%4, column n/4.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv ? inv_sbox(s[127-8*n -: 8]) : sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  // Circulant matrix: element (row r, input k) uses coefficient (k - r) mod 4.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  cf;
    logic [7:0]   acc;
    o  = '0;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(cf[31-8*((k+4-r)%4) -: 8], s[127-8*(k+4*c) -: 8]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Full key schedule, returning round key idx (words 4*idx .. 4*idx+3).
  function automatic logic [127:0] round_key(input logic [KEY_LEN-1:0] key,
                                             input logic [3:0]         idx);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = key[KEY_LEN-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-NK] ^ t;
      end
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] rev128(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = x[127-i];
    return r;
  endfunction

  function automatic logic [KEY_LEN-1:0] rev_key(input logic [KEY_LEN-1:0] x);
    logic [KEY_LEN-1:0] r;
    for (int i = 0; i < KEY_LEN; i++) r[i] = x[KEY_LEN-1-i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic               mode_q, mode_d;
  logic [KEY_LEN-1:0] key_q, key_d;
  logic [127:0]       blk_q, blk_d;
  logic               out_valid_q, out_valid_d;
  logic [127:0]       out_data_q, out_data_d;
  logic               out_mode_q, out_mode_d;

  logic               accept;
  logic               last;
  logic [KEY_LEN-1:0] in_key_c;
  logic [127:0]       in_data_c;
  logic [KEY_LEN-1:0] ks_key;
  logic [3:0]         rk_idx;
  logic [127:0]       rk;
  logic [127:0]       enc_sr, enc_rnd;
  logic [127:0]       dec_ark, dec_rnd;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (round_q == NR_L);
  assign in_key_c  = rev_key(in_key);
  assign in_data_c = rev128(in_data);

  // On the accept cycle the schedule runs from the incoming key so the
  // initial whitening key (rk[0] or rk[Nr]) is available immediately.
  always_comb begin
    ks_key = key_q;
    rk_idx = mode_q ? (NR_L - round_q) : round_q;
    if (accept) begin
      ks_key = in_key_c;
      rk_idx = in_mode ? NR_L : 4'd0;
    end
  end

  assign rk = round_key(ks_key, rk_idx);

  // Encrypt: SubBytes, ShiftRows, MixColumns (not in last round), AddRoundKey.
  assign enc_sr  = shift_rows(sub_bytes(blk_q, 1'b0), 1'b0);
  assign enc_rnd = (last ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rk;
  // Decrypt: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (not last).
  assign dec_ark = sub_bytes(shift_rows(blk_q, 1'b1), 1'b1) ^ rk;
  assign dec_rnd = last ? dec_ark : mix_columns(dec_ark, 1'b1);

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    mode_d      = mode_q;
    key_d       = key_q;
    blk_d       = blk_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    case (state_q)
      S_RUN: begin
        blk_d = mode_q ? dec_rnd : enc_rnd;
        if (last) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_data_d  = blk_d;
          out_mode_d  = mode_q;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A new request overrides the DONE->IDLE exit; the result it replaces
    // has been taken on this same edge.
    if (accept) begin
      state_d = S_RUN;
      round_d = 4'd1;
      mode_d  = in_mode;
      key_d   = in_key_c;
      blk_d   = in_data_c ^ rk;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = rev128(out_data_q);
  assign out_mode  = out_mode_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_round_iter_core.sv
// -----------------------------------------------------------------------------
// tb_aes_round_iter_core
//   Directed bench for aes_round_iter_core with one instance per key length.
//   Vectors are the FIPS-197 known answers, written as hex with byte 0 first;
//   the bench maps them onto the ports where vector bit 0 is the MSB of byte 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_round_iter_core;

  localparam logic [127:0] KA    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PTA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, in_mode, out_ready;
  logic [127:0] in_data;
  logic         iv128, iv192, iv256;
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  logic         ir128, ir192, ir256, ov128, ov192, ov256;
  logic         om128, om192, om256, bs128, bs192, bs256;
  logic [127:0] od128, od192, od256;

  int n_assert = 0;
  int n_fail   = 0;

  aes_round_iter_core #(.KEY_LEN(128)) u128 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv128), .in_ready(ir128), .in_mode(in_mode),
    .in_key(k128), .in_data(in_data), .out_valid(ov128), .out_ready(out_ready),
    .out_data(od128), .out_mode(om128), .busy(bs128));

  aes_round_iter_core #(.KEY_LEN(192)) u192 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv192), .in_ready(ir192), .in_mode(in_mode),
    .in_key(k192), .in_data(in_data), .out_valid(ov192), .out_ready(out_ready),
    .out_data(od192), .out_mode(om192), .busy(bs192));

  aes_round_iter_core #(.KEY_LEN(256)) u256 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv256), .in_ready(ir256), .in_mode(in_mode),
    .in_key(k256), .in_data(in_data), .out_valid(ov256), .out_ready(out_ready),
    .out_data(od256), .out_mode(om256), .busy(bs256));

  function automatic logic [255:0] rev_bits(input logic [255:0] x, input int w);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[w-1-i];
    return r;
  endfunction

  function automatic logic rd_valid(input int w);
    return (w == 128) ? ov128 : (w == 192) ? ov192 : ov256;
  endfunction
  function automatic logic rd_ready(input int w);
    return (w == 128) ? ir128 : (w == 192) ? ir192 : ir256;
  endfunction
  function automatic logic rd_busy(input int w);
    return (w == 128) ? bs128 : (w == 192) ? bs192 : bs256;
  endfunction
  function automatic logic rd_mode(input int w);
    return (w == 128) ? om128 : (w == 192) ? om192 : om256;
  endfunction
  function automatic logic [127:0] rd_data(input int w);
    return (w == 128) ? od128 : (w == 192) ? od192 : od256;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: presents a request, checks in_ready, and returns
  // at the falling edge right after the accepting rising edge.
  task automatic start(input int w, input logic mode, input logic [255:0] key,
                       input logic [127:0] data, input string tag);
    logic [255:0] kr;
    logic [255:0] dr;
    kr      = rev_bits(key, w);
    dr      = rev_bits({128'h0, data}, 128);
    in_mode = mode;
    in_data = dr[127:0];
    if (w == 128) begin k128 = kr[127:0]; iv128 = 1'b1; end
    else if (w == 192) begin k192 = kr[191:0]; iv192 = 1'b1; end
    else begin k256 = kr; iv256 = 1'b1; end
    #1;
    chk_bit({tag, ".in_ready"}, rd_ready(w), 1'b1);
    @(negedge clk);
    iv128 = 1'b0;
    iv192 = 1'b0;
    iv256 = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid, bounded.
  task automatic wait_result(input int w, input logic mode, input logic [127:0] exp,
                             input int lat, input string tag);
    int           cyc;
    logic [255:0] got;
    cyc = 0;
    while (!rd_valid(w) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    got = rev_bits({128'h0, rd_data(w)}, 128);
    chk_int({tag, ".latency"}, cyc, lat);
    chk_blk({tag, ".data"}, got[127:0], exp);
    chk_bit({tag, ".mode"}, rd_mode(w), mode);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           ws [3];
    logic         ok;
    logic [127:0] snap;
    ws        = '{128, 192, 256};
    reset_n   = 1'b0;
    out_ready = 1'b1;
    in_mode   = 1'b0;
    in_data   = '0;
    iv128 = 1'b0; iv192 = 1'b0; iv256 = 1'b0;
    k128 = '0; k192 = '0; k256 = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk_bit("reset.out_valid", rd_valid(ws[i]), 1'b0);
      chk_bit("reset.in_ready", rd_ready(ws[i]), 1'b1);
      chk_bit("reset.busy", rd_busy(ws[i]), 1'b0);
      chk_bit("reset.out_mode", rd_mode(ws[i]), 1'b0);
      chk_blk("reset.out_data", rd_data(ws[i]), 128'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // T1 / T2: AES-128 encrypt, then decrypt back-to-back
    start(128, 1'b0, {128'h0, KA}, PTA, "t1");
    chk_bit("t1.busy", bs128, 1'b1);
    chk_bit("t1.in_ready_run", ir128, 1'b0);
    wait_result(128, 1'b0, CTA, 10, "t1");
    start(128, 1'b1, {128'h0, KA}, CTA, "t2");
    wait_result(128, 1'b1, PTA, 10, "t2");

    // T3: AES-192 and AES-256 round trips
    start(192, 1'b0, {64'h0, K192}, PTA, "t3_192e");
    wait_result(192, 1'b0, CT192, 12, "t3_192e");
    start(192, 1'b1, {64'h0, K192}, CT192, "t3_192d");
    wait_result(192, 1'b1, PTA, 12, "t3_192d");
    start(256, 1'b0, K256, PTA, "t3_256e");
    wait_result(256, 1'b0, CT256, 14, "t3_256e");
    start(256, 1'b1, K256, CT256, "t3_256d");
    wait_result(256, 1'b1, PTA, 14, "t3_256d");

    // T4: backpressure on the 192-bit core
    @(negedge clk);
    out_ready = 1'b0;
    start(192, 1'b0, {64'h0, K192}, PTA, "t4");
    wait_result(192, 1'b0, CT192, 12, "t4");
    snap = od192;
    ok   = 1'b1;
    repeat (20) begin
      @(negedge clk);
      ok = ok & (ov192 === 1'b1) & (od192 === snap) & (ir192 === 1'b0) & (om192 === 1'b0);
    end
    chk_bit("t4.hold_stable", ok, 1'b1);
    out_ready = 1'b1;
    start(192, 1'b1, {64'h0, K192}, CT192, "t4_next");
    chk_bit("t4.out_valid_cleared", ov192, 1'b0);
    chk_bit("t4.busy_next", bs192, 1'b1);
    wait_result(192, 1'b1, PTA, 12, "t4_next");

    // T5: alternating modes and keys, out_ready held high
    start(128, 1'b0, {128'h0, KB}, PTB, "t5a");
    wait_result(128, 1'b0, CTB, 10, "t5a");
    start(128, 1'b1, {128'h0, KA}, CTA, "t5b");
    wait_result(128, 1'b1, PTA, 10, "t5b");
    start(128, 1'b1, {128'h0, KB}, CTB, "t5c");
    wait_result(128, 1'b1, PTB, 10, "t5c");
    start(128, 1'b0, {128'h0, KA}, PTA, "t5d");
    wait_result(128, 1'b0, CTA, 10, "t5d");

    // T6: reset in the middle of an AES-256 block
    @(negedge clk);
    start(256, 1'b0, K256, PTB, "t6");
    repeat (4) @(negedge clk);
    chk_bit("t6.busy_mid", bs256, 1'b1);
    chk_bit("t6.in_ready_mid", ir256, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_bit("t6.out_valid_rst", ov256, 1'b0);
    chk_bit("t6.busy_rst", bs256, 1'b0);
    chk_bit("t6.in_ready_rst", ir256, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_bit("t6.no_pulse", ov256, 1'b0);
    start(256, 1'b0, K256, PTA, "t6_after");
    wait_result(256, 1'b0, CT256, 14, "t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
